// File: rtl/hyper_pkg.sv
// hyper_pkg: shared state encoding, default watchdog limit and a length helper
// for the hyper_arb HyperRAM bridge arbiter.
package hyper_pkg;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        ISSUE    = 3'd1,
        WAIT_BSY = 3'd2,
        RUN      = 3'd3,
        DONE     = 3'd4
    } state_t;

    localparam logic [15:0] DEF_TIMEOUT = 16'd1024;

    // A zero-length read burst still fetches one dword.
    function automatic logic [5:0] fix_len(input logic [5:0] n);
        return (n == 6'd0) ? 6'd1 : n;
    endfunction

endpackage

// File: rtl/hyper_rr_sel.sv
// hyper_rr_sel: 2-way round-robin selector; on a tie the port that was
// not granted last wins.
module hyper_rr_sel (
    input  logic [1:0] req,
    input  logic       last,
    output logic [1:0] grant,
    output logic       owner
);

    always_comb begin
        owner = 1'b0;
        if (req == 2'b11) begin
            owner = ~last;
        end else if (req[1]) begin
            owner = 1'b1;
        end
        grant = 2'b00;
        if (req != 2'b00) begin
            grant = owner ? 2'b10 : 2'b01;
        end
    end

endmodule

// File: rtl/hyper_arb.sv
// hyper_arb: two-port round-robin arbiter/sequencer in front of hyper_xface.
// Optional watchdog abort enabled with `define HYPER_ARB_TIMEOUT_EN.
module hyper_arb
    import hyper_pkg::*;
#(
    parameter logic [15:0] TIMEOUT_CYCLES = DEF_TIMEOUT
) (
    input  logic        clk,
    input  logic        reset_l,
    input  logic        p0_req,
    input  logic        p0_rd,
    input  logic        p0_mem_or_reg,
    input  logic [3:0]  p0_byte_en,
    input  logic [31:0] p0_addr,
    input  logic [31:0] p0_wr_d,
    input  logic [5:0]  p0_num_dwords,
    output logic [31:0] p0_rd_d,
    output logic        p0_rd_rdy,
    output logic        p0_done,
    output logic        p0_err,
    input  logic        p1_req,
    input  logic        p1_rd,
    input  logic        p1_mem_or_reg,
    input  logic [3:0]  p1_byte_en,
    input  logic [31:0] p1_addr,
    input  logic [31:0] p1_wr_d,
    input  logic [5:0]  p1_num_dwords,
    output logic [31:0] p1_rd_d,
    output logic        p1_rd_rdy,
    output logic        p1_done,
    output logic        p1_err,
    output logic        x_rd_req,
    output logic        x_wr_req,
    output logic        x_mem_or_reg,
    output logic [3:0]  x_wr_byte_en,
    output logic [31:0] x_addr,
    output logic [31:0] x_wr_d,
    output logic [5:0]  x_rd_num_dwords,
    input  logic [31:0] x_rd_d,
    input  logic        x_rd_rdy,
    input  logic        x_busy,
    output logic [7:0]  sump_dbg
);

    state_t     state;
    state_t     state_nx;
    logic       owner;
    logic       last;
    logic       sel_owner;
    logic [1:0] grant;
    logic       rd_op;
    logic       err_q;
    logic       err_nx;
    logic       tmo_hit;
    logic       start;
    logic       rd_live;

    hyper_rr_sel u_sel (
        .req   ({p1_req, p0_req}),
        .last  (last),
        .grant (grant),
        .owner (sel_owner)
    );

    assign start = (state == IDLE) && (|grant);

`ifdef HYPER_ARB_TIMEOUT_EN
    logic [15:0] tmo_cnt;

    // Hitting limit-1 here means the count reaches the limit on entry to DONE.
    assign tmo_hit = (tmo_cnt == TIMEOUT_CYCLES - 16'd1);

    always_ff @(posedge clk or negedge reset_l) begin
        if (!reset_l) begin
            tmo_cnt <= 16'd0;
        end else if (state == ISSUE) begin
            tmo_cnt <= 16'd0;
        end else if (state == WAIT_BSY || state == RUN) begin
            tmo_cnt <= tmo_cnt + 16'd1;
        end
    end
`else
    logic unused_tmo;

    assign tmo_hit    = 1'b0;
    assign unused_tmo = ^TIMEOUT_CYCLES;
`endif

    always_comb begin
        state_nx = state;
        err_nx   = err_q;
        unique case (state)
            IDLE: begin
                if (start) begin
                    state_nx = ISSUE;
                    err_nx   = 1'b0;
                end
            end
            ISSUE: state_nx = WAIT_BSY;
            WAIT_BSY: begin
                if (tmo_hit) begin
                    state_nx = DONE;
                    err_nx   = 1'b1;
                end else if (x_busy) begin
                    state_nx = RUN;
                end
            end
            RUN: begin
                if (tmo_hit) begin
                    state_nx = DONE;
                    err_nx   = 1'b1;
                end else if (!x_busy) begin
                    state_nx = DONE;
                end
            end
            DONE: state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_l) begin
        if (!reset_l) begin
            state           <= IDLE;
            owner           <= 1'b0;
            last            <= 1'b1;
            err_q           <= 1'b0;
            rd_op           <= 1'b0;
            x_mem_or_reg    <= 1'b0;
            x_wr_byte_en    <= 4'd0;
            x_addr          <= 32'd0;
            x_wr_d          <= 32'd0;
            x_rd_num_dwords <= 6'd0;
        end else begin
            state <= state_nx;
            err_q <= err_nx;
            if (start) begin
                owner           <= sel_owner;
                rd_op           <= sel_owner ? p1_rd : p0_rd;
                x_mem_or_reg    <= sel_owner ? p1_mem_or_reg : p0_mem_or_reg;
                x_wr_byte_en    <= sel_owner ? p1_byte_en : p0_byte_en;
                x_addr          <= sel_owner ? p1_addr : p0_addr;
                x_wr_d          <= sel_owner ? p1_wr_d : p0_wr_d;
                x_rd_num_dwords <= fix_len(sel_owner ? p1_num_dwords
                                                     : p0_num_dwords);
            end
            if (state == DONE) begin
                last <= owner;
            end
        end
    end

    assign x_rd_req = (state == ISSUE) && rd_op;
    assign x_wr_req = (state == ISSUE) && !rd_op;

    // Stray read strobes outside an active transaction are discarded.
    assign rd_live   = (state == WAIT_BSY || state == RUN) && x_rd_rdy;
    assign p0_rd_rdy = rd_live && !owner;
    assign p1_rd_rdy = rd_live && owner;
    assign p0_rd_d   = p0_rd_rdy ? x_rd_d : 32'd0;
    assign p1_rd_d   = p1_rd_rdy ? x_rd_d : 32'd0;

    assign p0_done = (state == DONE) && !owner;
    assign p1_done = (state == DONE) && owner;
    assign p0_err  = p0_done && err_q;
    assign p1_err  = p1_done && err_q;

    assign sump_dbg = {owner, state[2:0], p1_req, p0_req, x_busy, x_rd_rdy};

endmodule
